mfp_ahb_single_master: RTL and testbench

- AHB-Lite initiator that turns a simple valid/ready command into one single-beat, word-sized transfer on the MFP AHB-Lite bus.
- It then returns read data, error status and a wait-state count on a one-cycle response strobe.
- It lets hardware agents (Rojobot control logic, test engines) drive the existing memory-mapped peripherals (GPIO LEDs/switches/pushbuttons) without the MIPS core.
- Transfers are non-overlapped: the next address phase never coincides with the current data phase.

---
 rtl/mfp_ahb_single_master_if.sv | 37 +++
 rtl/mfp_ahb_single_master.sv | 97 +++++++++
 tb/tb_mfp_ahb_single_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_ahb_single_master_if.sv
// Command/response handshake plus AHB-Lite master signals of the single-beat initiator.
// The master modport is the initiator's view; slave is the agent/responder side.
interface mfp_ahb_single_master_if #(
  parameter int unsigned WAIT_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [31:0]       cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [WAIT_W-1:0] rsp_waits;
  logic              busy;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_waits, busy,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_waits, busy,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );
endinterface

// File: rtl/mfp_ahb_single_master.sv
// AHB-Lite single-beat initiator: each accepted command becomes one non-overlapped word transfer,
// answered by a one-cycle response strobe with read data, error flag and wait-state count.
module mfp_ahb_single_master #(
  parameter int unsigned WAIT_W = 8
) (
  input logic                     HCLK,
  input logic                     HRESET,
  mfp_ahb_single_master_if.master bus
);
  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  localparam logic [1:0]        HtransIdle   = 2'b00;
  localparam logic [1:0]        HtransNonseq = 2'b10;
  localparam logic [WAIT_W-1:0] WaitMax      = '1;

  state_e            state_q;
  logic [31:0]       haddr_q;
  logic [31:0]       hwdata_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [1:0]        htrans_q;
  logic              hwrite_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] rsp_waits_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= StIdle;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      htrans_q    <= HtransIdle;
      hwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
      rsp_waits_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            haddr_q  <= {bus.cmd_addr[31:2], 2'b00};
            hwrite_q <= bus.cmd_write;
            wdata_q  <= bus.cmd_wdata;
            htrans_q <= HtransNonseq;
            state_q  <= StAddr;
          end
        end
        StAddr: begin
          // Dropping HTRANS here keeps the data phase free of any new address phase.
          if (bus.HREADY) begin
            htrans_q   <= HtransIdle;
            wait_cnt_q <= '0;
            if (hwrite_q) begin
              hwdata_q <= wdata_q;
            end
            state_q    <= StData;
          end
        end
        StData: begin
          if (bus.HREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.HRESP;
            rsp_rdata_capture();
            rsp_waits_q <= wait_cnt_q;
            state_q     <= StIdle;
          end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Writes report zero read data.
  function automatic void rsp_rdata_capture();
    rdata_q <= hwrite_q ? 32'h0 : bus.HRDATA;
  endfunction

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_waits = rsp_waits_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HSIZE     = 3'b010;
  assign bus.HBURST    = 3'b000;
  assign bus.HWDATA    = hwdata_q;
endmodule

// File: tb/tb_mfp_ahb_single_master.sv
// Bench for mfp_ahb_single_master: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against a timestamp-based transfer model.
module tb_mfp_ahb_single_master;
  localparam int unsigned WaitW   = 4;
  localparam int          WaitMax = (1 << WaitW) - 1;

  logic HCLK = 1'b0;
  logic HRESET;

  mfp_ahb_single_master_if #(.WAIT_W(WaitW)) bus ();

  mfp_ahb_single_master #(.WAIT_W(WaitW)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Transfer model: each transfer is described by the edge it was accepted, the edge its
  // address phase ended and the edge it completed; outputs follow from those timestamps.
  longint      edge_n = 0;
  longint      t_aend = -1;
  longint      t_done = -1;
  longint      dw;
  bit          m_on = 0;
  bit          m_inflight = 0;
  bit          cur_write = 0;
  logic [31:0] cur_wdata = '0;
  logic [31:0] e_haddr = '0;
  logic        e_hwrite = 1'b0;
  logic [31:0] e_hwdata = '0;
  logic [31:0] e_rdata = '0;
  logic        e_err = 1'b0;
  int          e_waits = 0;

  always @(posedge HCLK) begin
    edge_n++;
    if (HRESET) begin
      m_on = 1; m_inflight = 0; t_aend = -1; t_done = -1;
      e_haddr = '0; e_hwrite = 1'b0; e_hwdata = '0; e_rdata = '0; e_err = 1'b0; e_waits = 0;
    end else if (!m_inflight) begin
      if (bus.cmd_valid) begin
        m_inflight = 1; t_aend = -1;
        cur_write = bus.cmd_write; cur_wdata = bus.cmd_wdata;
        e_haddr = bus.cmd_addr & 32'hFFFF_FFFC; e_hwrite = bus.cmd_write;
      end
    end else if (t_aend < 0) begin
      if (bus.HREADY) begin
        t_aend = edge_n;
        if (cur_write) e_hwdata = cur_wdata;
      end
    end else if (bus.HREADY) begin
      m_inflight = 0; t_done = edge_n;
      dw = edge_n - t_aend - 1;
      e_waits = (dw > WaitMax) ? WaitMax : int'(dw);
      e_err = bus.HRESP;
      e_rdata = cur_write ? 32'h0 : bus.HRDATA;
    end
  end

  always @(negedge HCLK) begin
    if (m_on) begin
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_inflight));
      chk("busy", 32'(bus.busy), 32'(m_inflight));
      chk("HTRANS", 32'(bus.HTRANS), (m_inflight && t_aend < 0) ? 32'h2 : 32'h0);
      chk("HADDR", bus.HADDR, e_haddr);
      chk("HWRITE", 32'(bus.HWRITE), 32'(e_hwrite));
      chk("HWDATA", bus.HWDATA, e_hwdata);
      chk("HSIZE", 32'(bus.HSIZE), 32'h2);
      chk("HBURST", 32'(bus.HBURST), 32'h0);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(t_done == edge_n));
      chk("rsp_rdata", bus.rsp_rdata, e_rdata);
      chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
      chk("rsp_waits", 32'(bus.rsp_waits), 32'(e_waits));
    end
  end

  // Responder-side LED register at 0xBF80_0000, written when a write data phase completes.
  logic [31:0] led_reg = '0;
  logic        dp_pend = 1'b0;
  logic        dp_led = 1'b0;
  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_pend <= 1'b0;
    end else if (bus.HREADY) begin
      if (dp_pend && dp_led) led_reg <= bus.HWDATA;
      dp_pend <= (bus.HTRANS == 2'b10);
      dp_led  <= bus.HWRITE && (bus.HADDR == 32'hBF80_0000);
    end
  end

  task automatic cyc();
    @(negedge HCLK);
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_valid = 1'b1;
    cyc();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy, vld;
    int   k, nns, nrsp, last_ns;

    HRESET = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    repeat (3) cyc();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
    chk("rst_haddr", bus.HADDR, 32'h0);
    HRESET = 1'b0;

    // Zero-wait write.
    send(1'b1, 32'hBF80_0000, 32'h0000_A5A5);
    chk("wr_c1_htrans", 32'(bus.HTRANS), 32'h2);
    chk("wr_c1_haddr", bus.HADDR, 32'hBF80_0000);
    chk("wr_c1_hwrite", 32'(bus.HWRITE), 32'h1);
    cyc();
    chk("wr_c2_hwdata", bus.HWDATA, 32'h0000_A5A5);
    chk("wr_c2_htrans", 32'(bus.HTRANS), 32'h0);
    cyc();
    chk("wr_c3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("wr_c3_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("wr_c3_rsp_waits", 32'(bus.rsp_waits), 32'h0);
    chk("wr_led_reg", led_reg, 32'h0000_A5A5);
    cyc();

    // Read with three data-phase waits.
    send(1'b0, 32'hBF80_0007, 32'hDEAD_BEEF);
    chk("rd_haddr", bus.HADDR, 32'hBF80_0004);
    cyc();
    bus.HREADY = 1'b0;
    repeat (3) begin
      cyc();
      chk("rd_wait_haddr", bus.HADDR, 32'hBF80_0004);
      chk("rd_wait_htrans", 32'(bus.HTRANS), 32'h0);
      chk("rd_wait_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    end
    bus.HREADY = 1'b1; bus.HRDATA = 32'h0000_1234;
    cyc();
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'h0000_1234);
    chk("rd_rsp_waits", 32'(bus.rsp_waits), 32'h3);
    bus.HRDATA = 32'h0;
    cyc();
    chk("rd_rsp_once", 32'(bus.rsp_valid), 32'h0);
    chk("rd_rdata_hold", bus.rsp_rdata, 32'h0000_1234);

    // Two-cycle ERROR response on a write.
    send(1'b1, 32'hBF80_0010, 32'h1111_2222);
    cyc();
    bus.HREADY = 1'b0; bus.HRESP = 1'b1;
    cyc();
    chk("err_dp_htrans", 32'(bus.HTRANS), 32'h0);
    bus.HREADY = 1'b1;
    cyc();
    chk("err_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("err_rsp_err", 32'(bus.rsp_err), 32'h1);
    chk("err_rsp_waits", 32'(bus.rsp_waits), 32'h1);
    chk("err_rsp_rdata", bus.rsp_rdata, 32'h0);
    bus.HRESP = 1'b0;
    cyc();

    // Back-to-back reads; the responder returns the observed HADDR as read data.
    k = 0; nns = 0; nrsp = 0; last_ns = -10;
    bus.cmd_write = 1'b0; bus.cmd_addr = 32'hBF80_0021; bus.cmd_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      rdy = bus.cmd_ready; vld = bus.cmd_valid;
      cyc();
      if (rdy && vld) begin
        k++;
        if (k < 4) bus.cmd_addr = 32'hBF80_0021 + 32'(4 * k);
        else bus.cmd_valid = 1'b0;
      end
      if (bus.HTRANS == 2'b10) begin
        if (nns > 0) chk("b2b_ns_gap", 32'(c - last_ns), 32'h3);
        chk("b2b_ns_haddr", bus.HADDR, 32'hBF80_0020 + 32'(4 * nns));
        bus.HRDATA = bus.HADDR;
        last_ns = c; nns++;
      end
      if (bus.rsp_valid) begin
        chk("b2b_rsp_order", bus.rsp_rdata, 32'hBF80_0020 + 32'(4 * nrsp));
        nrsp++;
      end
    end
    chk("b2b_ns_count", 32'(nns), 32'h4);
    chk("b2b_rsp_count", 32'(nrsp), 32'h4);

    // Wait counter saturation.
    send(1'b0, 32'hBF80_0008, 32'h0);
    cyc();
    bus.HREADY = 1'b0;
    repeat (20) cyc();
    bus.HREADY = 1'b1; bus.HRDATA = 32'hFEED_0001;
    cyc();
    chk("sat_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("sat_rsp_waits", 32'(bus.rsp_waits), 32'hF);
    chk("sat_rsp_rdata", bus.rsp_rdata, 32'hFEED_0001);
    cyc();

    // Reset during a stalled data phase.
    send(1'b0, 32'hBF80_000C, 32'h0);
    cyc();
    bus.HREADY = 1'b0;
    repeat (2) cyc();
    HRESET = 1'b1;
    cyc();
    chk("mrst_htrans", 32'(bus.HTRANS), 32'h0);
    chk("mrst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("mrst_busy", 32'(bus.busy), 32'h0);
    chk("mrst_haddr", bus.HADDR, 32'h0);
    chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mrst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("mrst_rsp_waits", 32'(bus.rsp_waits), 32'h0);
    HRESET = 1'b0; bus.HREADY = 1'b1;
    cyc();
    chk("mrst_no_rsp", 32'(bus.rsp_valid), 32'h0);
    send(1'b1, 32'hBF80_0000, 32'h0000_5A5A);
    cyc();
    cyc();
    chk("mrst_after_rsp", 32'(bus.rsp_valid), 32'h1);
    chk("mrst_after_led", led_reg, 32'h0000_5A5A);

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      cyc();
      HRESET        = ($urandom_range(0, 299) == 0);
      bus.cmd_valid = $urandom_range(0, 1) == 1;
      bus.cmd_write = $urandom_range(0, 1) == 1;
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      bus.HRDATA    = $urandom;
      bus.HREADY    = ($urandom_range(0, 3) != 0) || ($urandom_range(0, 40) == 0 && 1'b0);
      bus.HRESP     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        bus.HREADY = 1'b0;
        for (int j = 0; j < 18; j++) cyc();
      end
    end
    HRESET = 1'b0; bus.cmd_valid = 1'b0; bus.HREADY = 1'b1;
    repeat (5) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
